// File: rtl/tsn_cbs_pkg.sv
// Shared types for the 802.1Qav credit-based shaper: port FSM states, config entry, credit limits.
// Struct field widths follow the default CREDIT_WIDTH/SLOPE_WIDTH of tsn_cbs_credit_mng.
package tsn_cbs_pkg;

  localparam int CBS_CREDIT_W = 32;
  localparam int CBS_SLOPE_W  = 16;

  localparam logic signed [CBS_CREDIT_W-1:0] CBS_CREDIT_MAX = {1'b0, {(CBS_CREDIT_W-1){1'b1}}};
  localparam logic signed [CBS_CREDIT_W-1:0] CBS_CREDIT_MIN = {1'b1, {(CBS_CREDIT_W-1){1'b0}}};

  typedef enum logic {
    CBS_IDLE,
    CBS_TX
  } cbs_state_e;

  typedef struct packed {
    logic                           en;
    logic        [CBS_SLOPE_W-1:0]  idle_slope;
    logic        [CBS_SLOPE_W-1:0]  send_slope;
    logic signed [CBS_CREDIT_W-1:0] hicredit;
    logic signed [CBS_CREDIT_W-1:0] locredit;
  } cbs_cfg_t;

endpackage

// File: rtl/tsn_cbs_credit_unit.sv
// Per-queue credit register with the (a)-(e) update mux, saturating clamp and eligibility bit.
module tsn_cbs_credit_unit #(
  parameter int CREDIT_WIDTH = 32,
  parameter int SLOPE_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic        [SLOPE_WIDTH-1:0]  idle_slope,
  input  logic        [SLOPE_WIDTH-1:0]  send_slope,
  input  logic signed [CREDIT_WIDTH-1:0] hicredit,
  input  logic signed [CREDIT_WIDTH-1:0] locredit,
  input  logic                           active,
  input  logic                           beat,
  input  logic                           empty,
  output logic                           eligible
);

  localparam int SW = CREDIT_WIDTH + 1;

  logic signed [CREDIT_WIDTH-1:0] credit, credit_nxt, clamped;
  logic signed [SW-1:0]           cred_x, inc, dec, sum, hi_x, lo_x;
  logic                           neg, pos;

  assign neg = credit[CREDIT_WIDTH-1];
  assign pos = !neg && (|credit);

  // One extra bit of headroom so the clamp sees the true sum, never a wrapped one.
  always_comb begin
    cred_x = {credit[CREDIT_WIDTH-1], credit};
    inc    = $signed({{(SW-SLOPE_WIDTH){1'b0}}, idle_slope});
    dec    = $signed({{(SW-SLOPE_WIDTH){1'b0}}, send_slope});
    hi_x   = {hicredit[CREDIT_WIDTH-1], hicredit};
    lo_x   = {locredit[CREDIT_WIDTH-1], locredit};
    sum    = (active && beat) ? (cred_x - dec) : (cred_x + inc);
    if (sum > hi_x)      clamped = hicredit;
    else if (sum < lo_x) clamped = locredit;
    else                 clamped = sum[CREDIT_WIDTH-1:0];
  end

  always_comb begin
    credit_nxt = credit;
    if (!en)                credit_nxt = '0;
    else if (active) begin
      if (beat)             credit_nxt = clamped;
    end
    else if (!empty || neg) credit_nxt = clamped;
    else if (pos)           credit_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) credit <= '0;
    else     credit <= credit_nxt;
  end

  assign eligible = !empty && (!en || !neg);

endmodule

// File: rtl/tsn_cbs_credit_mng.sv
// Credit-based shaper manager for one TSN TX port: config table, port FSM, per-queue credit units.
// Define TSN_CBS_HILO_LIMIT_EN to clamp credits to the configured hi/lo limits instead of the signed extremes.
module tsn_cbs_credit_mng
  import tsn_cbs_pkg::*;
#(
  parameter int PORT_FIFO_PRI_NUM = 8,
  parameter int CREDIT_WIDTH      = CBS_CREDIT_W,
  parameter int SLOPE_WIDTH       = CBS_SLOPE_W
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_cfg_we,
  input  logic [$clog2(PORT_FIFO_PRI_NUM+1)-1:0] i_cfg_qidx,
  input  logic                                   i_cfg_cbs_en,
  input  logic [SLOPE_WIDTH-1:0]                 i_cfg_idle_slope,
  input  logic [SLOPE_WIDTH-1:0]                 i_cfg_send_slope,
  input  logic signed [CREDIT_WIDTH-1:0]         i_cfg_hicredit,
  input  logic signed [CREDIT_WIDTH-1:0]         i_cfg_locredit,
  input  logic [PORT_FIFO_PRI_NUM:0]             i_fifoc_empty,
  input  logic [PORT_FIFO_PRI_NUM:0]             i_scheduing_rst,
  input  logic                                   i_scheduing_rst_vld,
  input  logic                                   i_pmac_tx_axis_valid,
  input  logic                                   i_pmac_tx_axis_last,
  output logic [PORT_FIFO_PRI_NUM:0]             o_queque,
  output logic                                   o_queque_vld
);

  localparam int NQ = PORT_FIFO_PRI_NUM + 1;
  localparam int QW = $clog2(NQ);

  function automatic logic [QW-1:0] lowest_idx(input logic [NQ-1:0] v);
    lowest_idx = '0;
    for (int i = NQ-1; i >= 0; i--)
      if (v[i]) lowest_idx = QW'(i);
  endfunction

  cbs_cfg_t                     cfg_tbl [NQ];
  logic signed [CBS_CREDIT_W-1:0] lim_hi, lim_lo;

`ifdef TSN_CBS_HILO_LIMIT_EN
  assign lim_hi = CBS_CREDIT_W'(i_cfg_hicredit);
  assign lim_lo = CBS_CREDIT_W'(i_cfg_locredit);
`else
  // Without configurable limits the table pins hi/lo to the signed extremes: plain saturation.
  logic unused_cfg_limits;
  assign unused_cfg_limits = ^{i_cfg_hicredit, i_cfg_locredit};
  assign lim_hi = CBS_CREDIT_MAX;
  assign lim_lo = CBS_CREDIT_MIN;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NQ; i++)
        cfg_tbl[i] <= '{en: 1'b0, idle_slope: '0, send_slope: '0,
                        hicredit: CBS_CREDIT_MAX, locredit: CBS_CREDIT_MIN};
    end else if (i_cfg_we && (int'(i_cfg_qidx) < NQ)) begin
      cfg_tbl[i_cfg_qidx] <= '{en: i_cfg_cbs_en,
                               idle_slope: CBS_SLOPE_W'(i_cfg_idle_slope),
                               send_slope: CBS_SLOPE_W'(i_cfg_send_slope),
                               hicredit: lim_hi, locredit: lim_lo};
    end
  end

  cbs_state_e    state;
  logic [QW-1:0] act_q;

  // Grants arriving while a frame is in flight (including on its last beat) are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CBS_IDLE;
      act_q <= '0;
    end else begin
      case (state)
        CBS_IDLE:
          if (i_scheduing_rst_vld && (|i_scheduing_rst)) begin
            act_q <= lowest_idx(i_scheduing_rst);
            state <= CBS_TX;
          end
        CBS_TX:
          if (i_pmac_tx_axis_valid && i_pmac_tx_axis_last) state <= CBS_IDLE;
        default: state <= CBS_IDLE;
      endcase
    end
  end

  logic [NQ-1:0] elig;

  for (genvar q = 0; q < NQ; q++) begin : g_unit
    tsn_cbs_credit_unit #(
      .CREDIT_WIDTH (CREDIT_WIDTH),
      .SLOPE_WIDTH  (SLOPE_WIDTH)
    ) u_unit (
      .clk        (i_clk),
      .rst        (i_rst),
      .en         (cfg_tbl[q].en),
      .idle_slope (SLOPE_WIDTH'(cfg_tbl[q].idle_slope)),
      .send_slope (SLOPE_WIDTH'(cfg_tbl[q].send_slope)),
      .hicredit   (CREDIT_WIDTH'(cfg_tbl[q].hicredit)),
      .locredit   (CREDIT_WIDTH'(cfg_tbl[q].locredit)),
      .active     ((state == CBS_TX) && (act_q == QW'(q))),
      .beat       (i_pmac_tx_axis_valid),
      .empty      (i_fifoc_empty[q]),
      .eligible   (elig[q])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_queque     <= '0;
      o_queque_vld <= 1'b0;
    end else begin
      o_queque     <= elig;
      o_queque_vld <= (state == CBS_IDLE) && (|elig);
    end
  end

endmodule

// File: tb/tb_tsn_cbs_credit_mng.sv
// Directed bench for tsn_cbs_credit_mng: driver queues expected outputs per cycle, a monitor compares them.
module tb_tsn_cbs_credit_mng;

  localparam logic signed [31:0] MAXC = 32'sh7fffffff;
  localparam logic signed [31:0] MINC = 32'sh80000000;
`ifdef TSN_CBS_HILO_LIMIT_EN
  localparam int REC = 10;   // -100 floor, +10 per cycle
`else
  localparam int REC = 18;   // -180, +10 per cycle
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_cfg_we;
  logic [3:0]        i_cfg_qidx;
  logic              i_cfg_cbs_en;
  logic [15:0]       i_cfg_idle_slope, i_cfg_send_slope;
  logic signed [31:0] i_cfg_hicredit, i_cfg_locredit;
  logic [8:0]        i_fifoc_empty, i_scheduing_rst;
  logic              i_scheduing_rst_vld, i_pmac_tx_axis_valid, i_pmac_tx_axis_last;
  logic [8:0]        o_queque;
  logic              o_queque_vld;

  always #5 i_clk = ~i_clk;

  tsn_cbs_credit_mng dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_we(i_cfg_we), .i_cfg_qidx(i_cfg_qidx), .i_cfg_cbs_en(i_cfg_cbs_en),
    .i_cfg_idle_slope(i_cfg_idle_slope), .i_cfg_send_slope(i_cfg_send_slope),
    .i_cfg_hicredit(i_cfg_hicredit), .i_cfg_locredit(i_cfg_locredit),
    .i_fifoc_empty(i_fifoc_empty), .i_scheduing_rst(i_scheduing_rst),
    .i_scheduing_rst_vld(i_scheduing_rst_vld),
    .i_pmac_tx_axis_valid(i_pmac_tx_axis_valid), .i_pmac_tx_axis_last(i_pmac_tx_axis_last),
    .o_queque(o_queque), .o_queque_vld(o_queque_vld)
  );

  typedef struct {
    int         cyc;
    logic [8:0] q;
    logic       vld;
  } exp_t;

  exp_t  exp_q[$];
  string exp_nm[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = exp_nm.pop_front();
      checks++;
      if (o_queque !== e.q || o_queque_vld !== e.vld) begin
        errors++;
        $display("FAIL %s: got q=%h vld=%b, want q=%h vld=%b", n, o_queque, o_queque_vld, e.q, e.vld);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic ck(input string nm, input logic [8:0] q, input logic v);
    exp_t e;
    e.cyc = cyc; e.q = q; e.vld = v;
    exp_q.push_back(e);
    exp_nm.push_back(nm);
  endtask

  task automatic cfg(input int q, input int idle, input int send,
                     input logic signed [31:0] hi, input logic signed [31:0] lo);
    i_cfg_we = 1'b1; i_cfg_qidx = 4'(q); i_cfg_cbs_en = 1'b1;
    i_cfg_idle_slope = 16'(idle); i_cfg_send_slope = 16'(send);
    i_cfg_hicredit = hi; i_cfg_locredit = lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_cfg_we = 1'b0; i_cfg_qidx = '0; i_cfg_cbs_en = 1'b0;
    i_cfg_idle_slope = '0; i_cfg_send_slope = '0; i_cfg_hicredit = MAXC; i_cfg_locredit = MINC;
    i_fifoc_empty = '1; i_scheduing_rst = '0; i_scheduing_rst_vld = 1'b0;
    i_pmac_tx_axis_valid = 1'b0; i_pmac_tx_axis_last = 1'b0;

    // Test 1: reset, then all queues non-empty with shaping disabled
    tick(); ck("t1_reset", 9'h000, 1'b0);
    tick(); i_rst = 1'b0; i_fifoc_empty = '0;
    tick(); ck("t1_all_elig", 9'h1FF, 1'b1);
    tick(); ck("t1_all_elig2", 9'h1FF, 1'b1);

    // Test 2: q3 idle=10 send=40, 5 beats -> -200, 20 cycles to recover
    i_fifoc_empty = '1; cfg(3, 10, 40, MAXC, MINC);
    tick(); i_cfg_we = 1'b0; i_scheduing_rst = 9'h008; i_scheduing_rst_vld = 1'b1;
    tick(); i_scheduing_rst_vld = 1'b0; i_scheduing_rst = '0; i_fifoc_empty[3] = 1'b0;
    i_pmac_tx_axis_valid = 1'b1;
    tick(); ck("t2_tx_first", 9'h008, 1'b0);
    tick(); ck("t2_tx_neg", 9'h000, 1'b0);
    tick(2); i_pmac_tx_axis_last = 1'b1;
    tick(); i_pmac_tx_axis_valid = 1'b0; i_pmac_tx_axis_last = 1'b0;
    ck("t2_last", 9'h000, 1'b0);
    tick(); ck("t2_idle_neg", 9'h000, 1'b0);
    tick(19); ck("t2_rec_m10", 9'h000, 1'b0);
    tick(); ck("t2_rec_0", 9'h008, 1'b1);

    // Test 3: q2 idle=5 builds 50, empty zeroes it; a 60 debit then needs 12 cycles
    i_fifoc_empty = '1; cfg(2, 5, 60, MAXC, MINC);
    tick(); i_cfg_we = 1'b0; i_fifoc_empty[2] = 1'b0;
    tick(); ck("t3_ne", 9'h004, 1'b1);
    tick(9); ck("t3_ne_end", 9'h004, 1'b1); i_fifoc_empty[2] = 1'b1;
    tick(); ck("t3_empty", 9'h000, 1'b0);
    i_scheduing_rst = 9'h004; i_scheduing_rst_vld = 1'b1;
    tick(); i_scheduing_rst_vld = 1'b0; i_scheduing_rst = '0;
    i_pmac_tx_axis_valid = 1'b1; i_pmac_tx_axis_last = 1'b1;
    tick(); i_pmac_tx_axis_valid = 1'b0; i_pmac_tx_axis_last = 1'b0; i_fifoc_empty[2] = 1'b0;
    ck("t3_tx_done", 9'h000, 1'b0);
    tick(); ck("t3_debit", 9'h000, 1'b0);
    tick(11); ck("t3_rec_m5", 9'h000, 1'b0);
    tick(); ck("t3_rec_0", 9'h004, 1'b1);

    // Test 4: multi-bit grant picks q1; mid-frame and last-beat grants for q4 ignored
    i_fifoc_empty = '1; cfg(1, 10, 30, MAXC, MINC);
    tick(); cfg(4, 10, 30, MAXC, MINC);
    tick(); i_cfg_we = 1'b0; i_scheduing_rst = 9'h012; i_scheduing_rst_vld = 1'b1;
    tick(); i_scheduing_rst = 9'h010; i_pmac_tx_axis_valid = 1'b1;
    tick(); i_scheduing_rst_vld = 1'b0;
    tick(); i_scheduing_rst_vld = 1'b1; i_pmac_tx_axis_last = 1'b1;
    tick(); i_scheduing_rst_vld = 1'b0; i_scheduing_rst = '0;
    i_pmac_tx_axis_valid = 1'b0; i_pmac_tx_axis_last = 1'b0;
    i_fifoc_empty[1] = 1'b0; i_fifoc_empty[4] = 1'b0;
    tick(); ck("t4_q4_free", 9'h010, 1'b1);
    tick(8); ck("t4_q1_m10", 9'h010, 1'b1);
    tick(); ck("t4_q1_back", 9'h012, 1'b1);

    // Test 5: q5 send=60, 3 beats, locredit -100 (limit build) or saturation-free -180
    i_fifoc_empty = '1; cfg(5, 10, 60, 32'sd1000, -32'sd100);
    tick(); i_cfg_we = 1'b0; i_scheduing_rst = 9'h020; i_scheduing_rst_vld = 1'b1;
    tick(); i_scheduing_rst_vld = 1'b0; i_scheduing_rst = '0; i_pmac_tx_axis_valid = 1'b1;
    tick(2); i_pmac_tx_axis_last = 1'b1;
    tick(); i_pmac_tx_axis_valid = 1'b0; i_pmac_tx_axis_last = 1'b0; i_fifoc_empty[5] = 1'b0;
    tick(REC); ck("t5_floor_m10", 9'h000, 1'b0);
    tick(); ck("t5_floor_0", 9'h020, 1'b1);

    // Test 6: reset mid-frame on q6; trailing beats must not debit
    i_fifoc_empty = '1; cfg(6, 10, 50, MAXC, MINC);
    tick(); i_cfg_we = 1'b0; i_scheduing_rst = 9'h040; i_scheduing_rst_vld = 1'b1;
    tick(); i_scheduing_rst_vld = 1'b0; i_scheduing_rst = '0; i_pmac_tx_axis_valid = 1'b1;
    tick(); i_rst = 1'b1; i_fifoc_empty = '0;
    tick(); ck("t6_rst", 9'h000, 1'b0); i_rst = 1'b0; cfg(6, 10, 50, MAXC, MINC);
    tick(); i_cfg_we = 1'b0; ck("t6_idle", 9'h1FF, 1'b1); i_pmac_tx_axis_last = 1'b1;
    tick(); i_pmac_tx_axis_last = 1'b0; ck("t6_beats_ign", 9'h1FF, 1'b1);
    tick(); i_pmac_tx_axis_valid = 1'b0; ck("t6_no_debit", 9'h1FF, 1'b1);
    tick(2);

    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
      $fatal(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
